// File: rtl/sio_pkg.sv
// Shared constants and FSM state type for the SIO frame receiver.
// The SIO test pattern generator uses the same frame constants.
package sio_pkg;

  // Frame format shared by transmitter and receiver.
  localparam int SIO_FRAME_BITS = 10;
  localparam int SIO_MIN_ZEROS  = 16;

  // Receiver states: hunting for the start bit, shifting data, publishing the word.
  typedef enum logic [1:0] {
    HUNT = 2'd0,
    DATA = 2'd1,
    DONE = 2'd2
  } sio_state_e;

  // Number of bits needed to hold the values 0..max_val.
  function automatic int sio_cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/sio_sync_edge.sv
// Two-flop synchroniser for an asynchronous input, followed by an edge
// register. rise/fall are single-cycle pulses derived from the synchronised
// level, so an edge on the pin shows up as a pulse about three clocks later.
module sio_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchroniser chain plus one extra stage to compare against.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync = sync_q;
  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/sio_frame_rx.sv
// SIO frame receiver: oversamples the asynchronous SioClk/SioDat pair on
// MCLK and decodes frames of (>= MIN_ZEROS zeros, '1' start bit,
// FRAME_BITS data bits MSB first) into parallel words.
//
// Optional build macro SIO_RX_CHECK_EN adds ExpData, Mismatch and ErrCount
// for comparing each decoded word against an expected value.
//
// Output strobe: RxValid is a one-cycle valid with no ready; the consumer
// must capture RxData in the cycle RxValid is high (RxData also holds until
// the next frame). Mismatch, when present, is qualified by the same strobe.
//
// fsm_state and sio_lines expose the receiver state and the synchronised
// SioClk/SioDat levels for observation.
module sio_frame_rx
  import sio_pkg::*;
#(
  parameter int FRAME_BITS = SIO_FRAME_BITS,
  parameter int MIN_ZEROS  = SIO_MIN_ZEROS,
  parameter int TIMEOUT    = 2**20
) (
  input  logic                  MCLK,
  input  logic                  nReset,
  input  logic                  SioClk,
  input  logic                  SioDat,
  output logic [FRAME_BITS-1:0] RxData,
  output logic                  RxValid,
  output logic [15:0]           FrameCount,
  output logic                  LinkUp,
  output logic [1:0]            fsm_state,
  output logic [1:0]            sio_lines
`ifdef SIO_RX_CHECK_EN
  ,
  input  logic [FRAME_BITS-1:0] ExpData,
  output logic                  Mismatch,
  output logic [15:0]           ErrCount
`endif
);

  localparam int ZW = sio_cnt_width(MIN_ZEROS);
  localparam int BW = sio_cnt_width(FRAME_BITS - 1);
  localparam int TW = sio_cnt_width(TIMEOUT - 1);

  localparam logic [ZW-1:0] ZMAX  = ZW'(MIN_ZEROS);
  localparam logic [BW-1:0] BLAST = BW'(FRAME_BITS - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  sio_state_e state;
  sio_state_e state_next;

  logic                  clk_sync;
  logic                  clk_rise;
  logic                  clk_fall;
  logic                  dat_meta;
  logic                  dat_sync;
  logic                  sample_en;
  logic                  timeout;
  logic                  done_fire;
  logic [ZW-1:0]         zcnt;
  logic [BW-1:0]         bitcnt;
  logic [TW-1:0]         tcnt;
  logic [FRAME_BITS-1:0] shreg;

  // SioClk: synchronised level plus edge pulses.
  sio_sync_edge u_clk_sync (
    .clk   (MCLK),
    .rst_n (nReset),
    .din   (SioClk),
    .sync  (clk_sync),
    .rise  (clk_rise),
    .fall  (clk_fall)
  );

  // SioDat only needs its synchronised level; the same two-flop depth keeps
  // it aligned with the SioClk edge pulses.
  always_ff @(posedge MCLK or negedge nReset) begin
    if (!nReset) begin
      dat_meta <= 1'b0;
      dat_sync <= 1'b0;
    end else begin
      dat_meta <= SioDat;
      dat_sync <= dat_meta;
    end
  end

  // A falling SioClk edge lands mid-bit: that is where data is sampled.
  assign sample_en = clk_fall;
  assign timeout   = (tcnt == TLAST);
  assign done_fire = (state == DONE) && !timeout;

  // Link watchdog: cleared by any SioClk edge, restarts after firing.
  always_ff @(posedge MCLK or negedge nReset) begin
    if (!nReset) begin
      tcnt <= '0;
    end else if (clk_rise || clk_fall || timeout) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge MCLK or negedge nReset) begin
    if (!nReset) begin
      state <= HUNT;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state; a timeout overrides any sample in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      HUNT: begin
        if (sample_en && dat_sync && (zcnt == ZMAX)) state_next = DATA;
      end
      DATA: begin
        if (sample_en && (bitcnt == BLAST)) state_next = DONE;
      end
      DONE: begin
        state_next = HUNT;
      end
      default: begin
        state_next = HUNT;
      end
    endcase
    if (timeout) state_next = HUNT;
  end

  // Datapath: hunt-zero counter, data shifter and published outputs.
  always_ff @(posedge MCLK or negedge nReset) begin
    if (!nReset) begin
      zcnt       <= '0;
      bitcnt     <= '0;
      shreg      <= '0;
      RxData     <= '0;
      RxValid    <= 1'b0;
      FrameCount <= '0;
      LinkUp     <= 1'b0;
    end else begin
      RxValid <= 1'b0;
      if (timeout) begin
        // Link lost: drop any partial word and require fresh hunt zeros.
        LinkUp <= 1'b0;
        zcnt   <= '0;
      end else begin
        case (state)
          HUNT: begin
            if (sample_en) begin
              if (!dat_sync) begin
                if (zcnt != ZMAX) zcnt <= zcnt + ZW'(1);
              end else if (zcnt == ZMAX) begin
                bitcnt <= '0;
              end else begin
                // A '1' after too few zeros is a runt or glitch.
                zcnt <= '0;
              end
            end
          end
          DATA: begin
            if (sample_en) begin
              shreg  <= {shreg[FRAME_BITS-2:0], dat_sync};
              bitcnt <= bitcnt + BW'(1);
            end
          end
          DONE: begin
            RxData     <= shreg;
            RxValid    <= 1'b1;
            FrameCount <= FrameCount + 16'd1;
            LinkUp     <= 1'b1;
            zcnt       <= '0;
          end
          default: begin
            zcnt <= '0;
          end
        endcase
      end
    end
  end

`ifdef SIO_RX_CHECK_EN
  // Compare each completed word with the expected value; error count saturates.
  always_ff @(posedge MCLK or negedge nReset) begin
    if (!nReset) begin
      Mismatch <= 1'b0;
      ErrCount <= '0;
    end else begin
      Mismatch <= 1'b0;
      if (done_fire && (shreg != ExpData)) begin
        Mismatch <= 1'b1;
        if (ErrCount != 16'hFFFF) ErrCount <= ErrCount + 16'd1;
      end
    end
  end
`endif

  assign fsm_state = state;
  assign sio_lines = {clk_sync, dat_sync};

endmodule

// File: tb/tb_sio_frame_rx.sv
// Bench for sio_frame_rx: table of frames with hand-computed outcomes, plus
// hand-written sequences for timeout, mid-frame reset, back-to-back frames
// at MCLK/4 and (when SIO_RX_CHECK_EN is defined) expected-data checking.
module tb_sio_frame_rx;

  localparam int TO = 512;

  logic        mclk;
  logic        nreset;
  logic        sio_clk;
  logic        sio_dat;
  logic [9:0]  rx_data;
  logic        rx_valid;
  logic [15:0] frame_count;
  logic        link_up;
  logic [1:0]  fsm_state;
  logic [1:0]  sio_lines;
`ifdef SIO_RX_CHECK_EN
  logic [9:0]  exp_data;
  logic        mismatch;
  logic [15:0] err_count;
  int          exp_err;
`endif

  int n_checks;
  int n_pass;
  int valid_cnt;
  int exp_pulses;
  logic [9:0] exp_q[$];
  logic [9:0] last_word;

  typedef struct {
    int          zeros;
    logic [9:0]  data;
    int          half;
    logic        good;
    logic [15:0] fc;
    logic        link;
  } vec_t;

  vec_t vecs[6];

  sio_frame_rx #(.TIMEOUT(TO)) dut (
    .MCLK       (mclk),
    .nReset     (nreset),
    .SioClk     (sio_clk),
    .SioDat     (sio_dat),
    .RxData     (rx_data),
    .RxValid    (rx_valid),
    .FrameCount (frame_count),
    .LinkUp     (link_up),
    .fsm_state  (fsm_state),
    .sio_lines  (sio_lines)
`ifdef SIO_RX_CHECK_EN
    ,
    .ExpData    (exp_data),
    .Mismatch   (mismatch),
    .ErrCount   (err_count)
`endif
  );

  // Clock: 20 MHz MCLK.
  initial mclk = 1'b0;
  always #25 mclk = ~mclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge mclk);
  endtask

  // One bit cell: data changes with the rising SioClk edge. Starts and ends on a negedge.
  task automatic send_bit(input logic b, input int half);
    sio_dat = b;
    sio_clk = 1'b1;
    tick(half);
    sio_clk = 1'b0;
    tick(half);
  endtask

  task automatic send_head(input int zeros, input int half);
    for (int k = 0; k < zeros; k++) send_bit(1'b0, half);
    send_bit(1'b1, half);
  endtask

  task automatic send_frame(input int zeros, input logic [9:0] data, input int half);
    send_head(zeros, half);
    for (int k = 9; k >= 0; k--) send_bit(data[k], half);
    sio_dat = 1'b0;
  endtask

  // Scoreboard: every RxValid pulse must match the next expected word.
  always @(negedge mclk) begin
    if (nreset && rx_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_rxvalid", 32'(rx_data), 32'h0000_DEAD);
      end else begin
        logic [9:0] w;
        w = exp_q.pop_front();
        check("rx_data", 32'(rx_data), 32'(w));
`ifdef SIO_RX_CHECK_EN
        check("mismatch", 32'(mismatch), 32'(w != exp_data));
        if (w != exp_data) exp_err++;
`endif
      end
    end
  end

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    valid_cnt  = 0;
    exp_pulses = 0;
    last_word  = '0;
    nreset     = 1'b0;
    sio_clk    = 1'b0;
    sio_dat    = 1'b0;
`ifdef SIO_RX_CHECK_EN
    exp_data   = 10'h355;
    exp_err    = 0;
`endif

    //            zeros  data     half good fc      link
    vecs[0] = '{21, 10'h355, 10, 1'b1, 16'd1, 1'b1};
    vecs[1] = '{10, 10'h3FF, 10, 1'b0, 16'd1, 1'b1};  // runt: too few zeros
    vecs[2] = '{21, 10'h0AA, 10, 1'b1, 16'd2, 1'b1};
    vecs[3] = '{16, 10'h2C3, 10, 1'b1, 16'd3, 1'b1};  // exactly MIN_ZEROS
    vecs[4] = '{15, 10'h1E1, 10, 1'b0, 16'd3, 1'b1};  // one zero short
    vecs[5] = '{20, 10'h000,  8, 1'b1, 16'd4, 1'b1};

    // Reset held while the inputs toggle.
    tick(1);
    for (int i = 0; i < 8; i++) begin
      sio_clk = i[0];
      sio_dat = ~i[1];
      tick(1);
    end
    check("rst_rx_data", 32'(rx_data), 32'h0);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_frame_count", 32'(frame_count), 32'h0);
    check("rst_link_up", 32'(link_up), 32'h0);
    check("rst_fsm_state", 32'(fsm_state), 32'h0);
    check("rst_sio_lines", 32'(sio_lines), 32'h0);
`ifdef SIO_RX_CHECK_EN
    check("rst_mismatch", 32'(mismatch), 32'h0);
    check("rst_err_count", 32'(err_count), 32'h0);
`endif
    sio_clk = 1'b0;
    sio_dat = 1'b0;
    tick(1);
    nreset = 1'b1;
    tick(4);

    // Table-driven frames.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].good) begin
        exp_q.push_back(vecs[i].data);
        exp_pulses++;
        last_word = vecs[i].data;
      end
      send_frame(vecs[i].zeros, vecs[i].data, vecs[i].half);
      tick(8);
      check($sformatf("v%0d_pending", i), 32'(exp_q.size()), 32'h0);
      check($sformatf("v%0d_pulses", i), 32'(valid_cnt), 32'(exp_pulses));
      check($sformatf("v%0d_rx_data", i), 32'(rx_data), 32'(last_word));
      check($sformatf("v%0d_frame_count", i), 32'(frame_count), 32'(vecs[i].fc));
      check($sformatf("v%0d_link_up", i), 32'(link_up), 32'(vecs[i].link));
    end

    // Timeout: stall SioClk after 5 data bits.
    send_head(21, 10);
    for (int k = 0; k < 5; k++) send_bit(k[0], 10);
    sio_dat = 1'b0;
    tick(4);
    check("to_in_data", 32'(fsm_state), 32'h1);
    tick(TO + 10);
    check("to_link_up", 32'(link_up), 32'h0);
    check("to_fsm_state", 32'(fsm_state), 32'h0);
    check("to_pulses", 32'(valid_cnt), 32'(exp_pulses));
    check("to_frame_count", 32'(frame_count), 32'd4);
    exp_q.push_back(10'h155);
    exp_pulses++;
    send_frame(21, 10'h155, 10);
    tick(8);
    check("to_resume_pending", 32'(exp_q.size()), 32'h0);
    check("to_resume_pulses", 32'(valid_cnt), 32'(exp_pulses));
    check("to_resume_link_up", 32'(link_up), 32'h1);
    check("to_resume_frame_count", 32'(frame_count), 32'd5);

    // Reset in the middle of a frame.
    send_head(21, 10);
    for (int k = 0; k < 5; k++) send_bit(1'b1, 10);
    nreset = 1'b0;
`ifdef SIO_RX_CHECK_EN
    exp_err = 0;
`endif
    tick(2);
    check("mid_rst_frame_count", 32'(frame_count), 32'h0);
    check("mid_rst_link_up", 32'(link_up), 32'h0);
    check("mid_rst_rx_data", 32'(rx_data), 32'h0);
    check("mid_rst_fsm_state", 32'(fsm_state), 32'h0);
    sio_clk = 1'b0;
    sio_dat = 1'b0;
    nreset  = 1'b1;
    tick(4);
    check("mid_rst_pulses", 32'(valid_cnt), 32'(exp_pulses));

    // Back-to-back frames with SioClk = MCLK/4.
    exp_q.push_back(10'h000);
    exp_q.push_back(10'h3FF);
    exp_pulses += 2;
    send_frame(20, 10'h000, 2);
    send_frame(20, 10'h3FF, 2);
    tick(8);
    check("b2b_pending", 32'(exp_q.size()), 32'h0);
    check("b2b_pulses", 32'(valid_cnt), 32'(exp_pulses));
    check("b2b_rx_data", 32'(rx_data), 32'h3FF);
    check("b2b_frame_count", 32'(frame_count), 32'd2);
    check("b2b_link_up", 32'(link_up), 32'h1);

`ifdef SIO_RX_CHECK_EN
    check("b2b_err_count", 32'(err_count), 32'(exp_err));
    // Expected-data checking from a clean reset.
    nreset  = 1'b0;
    exp_err = 0;
    tick(2);
    nreset = 1'b1;
    tick(4);
    exp_q.push_back(10'h354);
    exp_pulses++;
    send_frame(21, 10'h354, 10);
    tick(8);
    check("chk_bad_pending", 32'(exp_q.size()), 32'h0);
    check("chk_bad_err_count", 32'(err_count), 32'd1);
    exp_q.push_back(10'h355);
    exp_pulses++;
    send_frame(21, 10'h355, 10);
    tick(8);
    check("chk_good_pending", 32'(exp_q.size()), 32'h0);
    check("chk_good_err_count", 32'(err_count), 32'd1);
    check("chk_frame_count", 32'(frame_count), 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
